// File: rtl/latch_write_sequencer_pkg.sv
// ============================================================================
// Module : latch_write_sequencer_pkg
// Brief  : Shared FSM state encoding, default timing constants and a helper
//          function for the latch write sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package latch_write_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int C_DEF_N_REQ     = 4;
    localparam int C_DEF_WIDTH     = 8;
    localparam int C_DEF_SETUP_CYC = 1;
    localparam int C_DEF_PULSE_CYC = 2;
    localparam int C_DEF_HOLD_CYC  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/latch_write_sequencer_rr_arbiter.sv
// ============================================================================
// Module : latch_write_sequencer_rr_arbiter
// Brief  : Combinational round-robin arbiter; searches upward from ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module latch_write_sequencer_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] winner
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/latch_write_sequencer.sv
// ============================================================================
// Module : latch_write_sequencer
// Brief  : Arbitrates N_REQ writers onto one latch bank and sequences
//          D setup -> EN pulse -> D hold so D never moves while EN is high.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module latch_write_sequencer
    import latch_write_sequencer_pkg::*;
#(
    parameter int N_REQ     = C_DEF_N_REQ,
    parameter int WIDTH     = C_DEF_WIDTH,
    parameter int SETUP_CYC = C_DEF_SETUP_CYC,
    parameter int PULSE_CYC = C_DEF_PULSE_CYC,
    parameter int HOLD_CYC  = C_DEF_HOLD_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [WIDTH-1:0]       d,
    output logic                   en
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

    if (N_REQ < 2 || SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_param_check
        $error("latch_write_sequencer: illegal parameters");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_idx_q, win_idx_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             en_q, en_d;

    logic [N_REQ-1:0] arb_winner;
    logic [PW-1:0]    arb_idx;
    logic [WIDTH-1:0] arb_data;
    logic [PW-1:0]    ptr_next;

    latch_write_sequencer_rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_winner)
    );

    always_comb begin
        arb_idx  = '0;
        arb_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_winner[i]) begin
                arb_idx  = PW'(i);
                arb_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (win_idx_q == PW'(N_REQ - 1)) ? '0 : win_idx_q + PW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        busy_d    = busy_q;
        d_d       = d_q;
        en_d      = en_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d   = ST_SETUP;
                    cnt_d     = CW'(SETUP_CYC - 1);
                    gnt_d     = arb_winner;
                    win_idx_d = arb_idx;
                    d_d       = arb_data;
                    busy_d    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = CW'(PULSE_CYC - 1);
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                    en_d    = 1'b0;
                    // A one-cycle HOLD makes the entry cycle the final one.
                    if (HOLD_CYC == 1) begin
                        done_d = gnt_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        done_d = gnt_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            win_idx_q <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            d_q       <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            d_q       <= d_d;
            en_q      <= en_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
    assign d    = d_q;
    assign en   = en_q;

endmodule

`default_nettype wire

// File: tb/tb_latch_write_sequencer.sv
// ============================================================================
// Module : tb_latch_write_sequencer
// Brief  : Scoreboard bench for latch_write_sequencer driving a latch bank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_latch_write_sequencer;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int PULSE = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   d;
    logic           en;
    wire  [W-1:0]   lq;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } sb_t;

    sb_t sb[$];
    sb_t e;
    int  n_checks = 0;
    int  n_err    = 0;
    int  en_run   = 0;

    latch_write_sequencer #(
        .N_REQ     (N),
        .WIDTH     (W),
        .SETUP_CYC (1),
        .PULSE_CYC (PULSE),
        .HOLD_CYC  (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .d     (d),
        .en    (en)
    );

    for (genvar i = 0; i < W; i++) begin : g_latch
        logic q;
        always_latch begin
            if (en) q <= d[i];
        end
        assign lq[i] = q;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check_eq("idle_reached", 32'(busy), 32'd0);
    endtask

    // Sideband monitor: EN pulse width, data/grant stability, DONE vs scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            en_run = 0;
        end else begin
            if (en) begin
                en_run++;
                check_eq("en_while_busy", 32'(busy), 32'd1);
            end else if (en_run != 0) begin
                check_eq("en_len", 32'(en_run), 32'(PULSE));
                en_run = 0;
            end
            if (busy && sb.size() != 0) begin
                check_eq("d_stable", 32'(d), 32'(sb[0].data));
                check_eq("gnt_hold", 32'(gnt), 32'(1 << sb[0].idx));
            end
            if (done != '0) begin
                if (sb.size() == 0) begin
                    check_eq("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("done_idx", 32'(done), 32'(1 << e.idx));
                    check_eq("latch_q", 32'(lq), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        wdata = '0;

        // Reset state
        tick(3);
        check_eq("rst_en",   32'(en),   32'd0);
        check_eq("rst_d",    32'(d),    32'h00);
        check_eq("rst_gnt",  32'(gnt),  32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Single write from requester 2
        wdata[23:16] = 8'hA5;
        req = 4'b0100;
        sb.push_back('{idx: 2, data: 8'hA5});
        tick();
        check_eq("t2_gnt",  32'(gnt),  32'b0100);
        check_eq("t2_d",    32'(d),    32'hA5);
        check_eq("t2_busy", 32'(busy), 32'd1);
        check_eq("t2_en_setup", 32'(en), 32'd0);
        tick();
        check_eq("t2_en_c2", 32'(en), 32'd1);
        tick();
        check_eq("t2_en_c3", 32'(en), 32'd1);
        tick();
        check_eq("t2_en_c4", 32'(en), 32'd0);
        check_eq("t2_done",  32'(done), 32'b0100);
        req = '0;
        tick();
        check_eq("t2_gnt_idle",  32'(gnt),  32'd0);
        check_eq("t2_busy_idle", 32'(busy), 32'd0);
        check_eq("t2_d_kept",    32'(d),    32'hA5);
        tick();

        // Round robin under full load, starting from pointer 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{idx: k % 4, data: 8'(8'h11 * ((k % 4) + 1))});
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("t3_rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            if (k < 4) tick(4);
        end
        tick(3);
        req = '0;
        wait_idle(4);
        check_eq("t3_sb_drained", 32'(sb.size()), 32'd0);

        // Requester 1 drops REQ mid-pulse; write still completes
        wdata[15:8] = 8'h5A;
        req = 4'b0010;
        sb.push_back('{idx: 1, data: 8'h5A});
        tick();
        check_eq("t4_gnt", 32'(gnt), 32'b0010);
        tick();
        check_eq("t4_en", 32'(en), 32'd1);
        req = '0;
        wait_idle(6);
        tick(2);
        check_eq("t4_no_regrant", 32'(gnt),  32'd0);
        check_eq("t4_busy",       32'(busy), 32'd0);
        check_eq("t4_sb_drained", 32'(sb.size()), 32'd0);

        // Reset asserted during the EN pulse
        wdata[7:0] = 8'h11;
        req = 4'b0001;
        tick(2);
        check_eq("t5_en_pre", 32'(en), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t5_en_async",   32'(en),   32'd0);
        check_eq("t5_busy_async", 32'(busy), 32'd0);
        check_eq("t5_gnt_async",  32'(gnt),  32'd0);
        req = '0;
        tick();
        rst = 1'b0;
        wdata[31:24] = 8'hC3;
        req = 4'b1000;
        sb.push_back('{idx: 3, data: 8'hC3});
        tick();
        check_eq("t5_gnt3", 32'(gnt), 32'b1000);
        tick(3);
        req = '0;
        wait_idle(4);

        // WDATA changes after grant are ignored
        wdata[7:0] = 8'h3C;
        req = 4'b0001;
        sb.push_back('{idx: 0, data: 8'h3C});
        tick();
        check_eq("t6_d_grant", 32'(d), 32'h3C);
        wdata[7:0] = 8'hFF;
        tick();
        check_eq("t6_d_pulse", 32'(d), 32'h3C);
        tick(2);
        req = '0;
        wait_idle(4);
        check_eq("t6_latch", 32'(lq), 32'h3C);
        check_eq("sb_final", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
